mem_arbiter: RTL and testbench

//  Shares one single-port backing memory between the fetch stage (IF port) and the memory stage (DM port) of the pipelined datapath.

---
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between fetch (IF) and data (DM) ports.
// Optional bus timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int MAX_DM_STREAK = 4
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  bus_err
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);

  typedef enum logic [1:0] {
    IDLE,
    IF_WAIT,
    DM_WAIT,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] streak;
  logic          streak_max;
  logic          grant_dm;
  logic          grant_if;
  logic          done;
  logic          tmo;
  logic          tmo_hit;

  assign streak_max = (streak == SW'(MAX_DM_STREAK));

`ifdef MEM_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wcnt;

  assign tmo_hit = (wcnt == WW'(TIMEOUT_CYCLES - 1));

  // count wait cycles without mem_ack since the grant
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt <= '0;
    end else if (grant_dm || grant_if) begin
      wcnt <= '0;
    end else if ((state == IF_WAIT || state == DM_WAIT) && !mem_ack) begin
      wcnt <= wcnt + 1'b1;
    end
  end

  // sticky error once a request has been abandoned by timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err <= 1'b0;
    end else if (tmo) begin
      bus_err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign bus_err = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state and grant/complete strobes
  always_comb begin
    state_nxt = state;
    grant_dm  = 1'b0;
    grant_if  = 1'b0;
    done      = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      IDLE: begin
        if (dm_req && !(if_req && streak_max)) begin
          grant_dm  = 1'b1;
          state_nxt = DM_WAIT;
        end else if (if_req) begin
          grant_if  = 1'b1;
          state_nxt = IF_WAIT;
        end
      end
      IF_WAIT, DM_WAIT: begin
        if (mem_ack) begin
          done      = 1'b1;
          state_nxt = RESP;
        end else if (tmo_hit) begin
          done      = 1'b1;
          tmo       = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // DM grants in a row while fetch waits; an IF grant or idle fetch clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
    end else if (grant_if) begin
      streak <= '0;
    end else if (grant_dm) begin
      if (!if_req) begin
        streak <= '0;
      end else if (!streak_max) begin
        streak <= streak + 1'b1;
      end
    end
  end

  // registered memory request and requester responses
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_ack    <= 1'b0;
      dm_rdata  <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      if (grant_dm) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (grant_if) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
      end
      if (done) begin
        mem_req <= 1'b0;
        if (state == IF_WAIT) begin
          if_ack   <= 1'b1;
          if_rdata <= tmo ? '0 : mem_rdata;
        end else begin
          dm_ack <= 1'b1;
          if (tmo) begin
            dm_rdata <= '0;
          end else if (!mem_we) begin
            dm_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: random requesters and memory latency
// against a transaction-level model of arbitration and data.
module tb_mem_arbiter;

  localparam int MAXS = 4;
  localparam int TO   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ack   (dm_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .bus_err  (bus_err)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] phys [16];
  logic [31:0] refm [16];

  bit          busy, ack_due, win_dm, win_we, prev_mreq, berr_m;
  logic [31:0] win_addr, win_wdata, last_dm;
  int          idle_cnt, streak, dly, waited;
  int          p_if, p_dm, fixed_dly;
  bit          order [$];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  task automatic step();
    bit can, rise, tmo, fin;
    int idx;
    @(negedge clk);
    can  = !busy && idle_cnt >= 1 && (if_req || dm_req);
    rise = mem_req && !prev_mreq;
    tmo  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    if (busy && !ack_due && waited >= TO) tmo = 1'b1;
`endif
    fin = ack_due || tmo;
    check("if_ack", if_ack, fin && !win_dm);
    check("dm_ack", dm_ack, fin && win_dm);
    check("bus_err", bus_err, berr_m || tmo);
    if (tmo) berr_m = 1'b1;
    if (fin) begin
      check("ack_mreq", mem_req, 0);
      idx = int'(win_addr[5:2]);
      if (!win_dm) begin
        check("if_rdata", if_rdata, tmo ? 32'h0 : refm[idx]);
      end else if (tmo) begin
        check("dm_rdata_tmo", dm_rdata, 0);
        last_dm = 32'h0;
      end else if (win_we) begin
        check("dm_rdata_keep", dm_rdata, last_dm);
        refm[idx] = win_wdata;
      end else begin
        check("dm_rdata", dm_rdata, refm[idx]);
        last_dm = refm[idx];
      end
      busy     = 1'b0;
      ack_due  = 1'b0;
      idle_cnt = 0;
    end else if (busy) begin
      check("hold_req", mem_req, 1);
      check("hold_addr", mem_addr, win_addr);
      check("hold_we", mem_we, win_we);
    end else begin
      check("grant", rise, can);
      if (rise) begin
        win_dm = dm_req && !(if_req && streak == MAXS);
        if (win_dm) begin
          win_addr  = dm_addr;
          win_we    = dm_we;
          win_wdata = dm_wdata;
          streak    = if_req ? ((streak < MAXS) ? streak + 1 : streak) : 0;
        end else begin
          win_addr = if_addr;
          win_we   = 1'b0;
          streak   = 0;
        end
        order.push_back(win_dm);
        check("grant_addr", mem_addr, win_addr);
        check("grant_we", mem_we, win_we);
        if (win_we) check("grant_wdata", mem_wdata, win_wdata);
        busy   = 1'b1;
        waited = 0;
        dly    = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
      end else begin
        idle_cnt++;
      end
    end
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (busy && !ack_due) begin
      if (dly == 0) begin
        mem_ack = 1'b1;
        ack_due = 1'b1;
        idx     = int'(mem_addr[5:2]);
        if (mem_we) phys[idx] = mem_wdata;
        else mem_rdata = phys[idx];
      end else begin
        dly--;
        waited++;
      end
    end
    if ((fin && !win_dm) || !if_req) begin
      if_req = ($urandom_range(0, 99) < p_if);
      if (if_req) if_addr = rnd_addr();
    end
    if ((fin && win_dm) || !dm_req) begin
      dm_req = ($urandom_range(0, 99) < p_dm);
      if (dm_req) begin
        dm_addr  = rnd_addr();
        dm_we    = $urandom_range(0, 1) == 1;
        dm_wdata = $urandom;
      end
    end
    prev_mreq = mem_req;
  endtask

  task automatic do_reset(int n);
    reset   = 1'b1;
    mem_ack = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("rst_mreq", mem_req, 0);
      check("rst_acks", {if_ack, dm_ack}, 0);
      check("rst_mem", {mem_we, mem_addr, mem_wdata}, 0);
      check("rst_rdata", {if_rdata, dm_rdata}, 0);
      check("rst_berr", bus_err, 0);
    end
    reset     = 1'b0;
    busy      = 1'b0;
    ack_due   = 1'b0;
    streak    = 0;
    idle_cnt  = 1;
    prev_mreq = 1'b0;
    berr_m    = 1'b0;
    last_dm   = 32'h0;
  endtask

  task automatic drain();
    int n = 0;
    p_if = 0;
    p_dm = 0;
    while ((busy || if_req || dm_req) && n < 300) begin
      step();
      n++;
    end
    check("drain_done", busy || if_req || dm_req, 0);
    repeat (2) step();
  endtask

  initial begin
    logic [31:0] keep;
    for (int i = 0; i < 16; i++) begin
      phys[i] = $urandom;
      refm[i] = phys[i];
    end
    p_if      = 0;
    p_dm      = 0;
    fixed_dly = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    if_req    = 1'b1;
    if_addr   = 32'h20;
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = 32'h10;
    dm_wdata  = 32'h0;

    // reset held with both requests pending; DM wins first
    do_reset(2);
    step();
    check("t1_dm_first", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h10});
    drain();

    // single IF read, same-cycle memory ack
    phys[1]   = 32'h0050_0093;
    refm[1]   = 32'h0050_0093;
    if_req    = 1'b1;
    if_addr   = 32'h4;
    step();
    check("t2_mem", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h4});
    step();
    check("t2_if_ack", if_ack, 1);
    check("t2_if_rdata", if_rdata, 32'h0050_0093);
    drain();

    // simultaneous requests: DM first, IF after the response cycle
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h100;
    if_req  = 1'b1;
    if_addr = 32'h8;
    repeat (4) step();
    check("t3_if_grant", {mem_req, mem_addr}, {1'b1, 32'h8});
    drain();

    // DM write leaves dm_rdata alone
    keep     = last_dm;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h100;
    dm_wdata = 32'hDEAD_BEEF;
    step();
    check("t4_wr", {mem_we, mem_wdata}, {1'b1, 32'hDEAD_BEEF});
    step();
    check("t4_ack", dm_ack, 1);
    check("t4_keep", dm_rdata, keep);
    drain();
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h100;
    repeat (2) step();
    check("t4_readback", dm_rdata, 32'hDEAD_BEEF);
    drain();

    // both held: four DM grants, then one IF grant, repeating
    order.delete();
    fixed_dly = -1;
    p_if      = 100;
    p_dm      = 100;
    if_req    = 1'b1;
    if_addr   = rnd_addr();
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = rnd_addr();
    repeat (60) step();
    check("t5_count", order.size() >= 10, 1);
    for (int k = 0; k < 10 && k < order.size(); k++)
      check("t5_order", order[k], (k % 5) != 4);
    drain();

    // random traffic
    p_if = 40;
    p_dm = 40;
    repeat (1500) step();
    drain();

    // memory never answers
    fixed_dly = 1000;
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = 32'h18;
`ifdef MEM_TIMEOUT_EN
    for (int n = 0; n < 40 && (busy || dm_req); n++) step();
    check("t6_done", busy, 0);
    repeat (3) step();
    check("t6_bus_err", bus_err, 1);
    do_reset(1);
`else
    repeat (100) step();
    check("t6_mreq_held", mem_req, 1);
    check("t6_no_err", bus_err, 0);
    do_reset(1);
    fixed_dly = 0;
    drain();
`endif

    // reset in the middle of a DM wait
    fixed_dly = 5;
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = 32'h2C;
    repeat (2) step();
    check("t7_busy", {mem_req, busy}, 2'b11);
    do_reset(1);
    fixed_dly = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
